mac_ctrl: RTL and testbench

Sequencer for the pipelined `mac` core. It fetches one dot-product job of `len` operand pairs from two synchronous operand RAMs and streams them into `mac` with `valid_in`/`eof` framing. It counts the core's `valid_out` pulses, captures the final accumulator value, and hands it to the host with a one-cycle `done` strobe. It sits between the host/command logic and a single `mac` instance, and is the only driver of that instance's inputs.

---
 rtl/mac_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mac_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_ctrl.sv
// mac_ctrl - sequencer for the pipelined mac core.
// Fetches len operand pairs from two synchronous RAMs, streams them into mac
// with valid_in/eof framing, counts valid_out pulses, captures the final
// accumulator into res and strobes done.
// Optional drain watchdog: define MAC_CTRL_TIMEOUT_EN.
module mac_ctrl #(
  parameter int A_WIDTH    = 8,
  parameter int B_WIDTH    = 8,
  parameter int OUT_WIDTH  = 18,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_WIDTH:0]         len,
  input  logic                        hold,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic signed [OUT_WIDTH-1:0] res,
  output logic                        rd_en,
  output logic [ADDR_WIDTH-1:0]       rd_addr,
  input  logic [A_WIDTH-1:0]          rd_a_data,
  input  logic [B_WIDTH-1:0]          rd_b_data,
  output logic                        mac_clear,
  output logic                        mac_enable,
  output logic                        mac_valid_in,
  output logic                        mac_eof,
  output logic [A_WIDTH-1:0]          mac_a,
  output logic [B_WIDTH-1:0]          mac_b,
  input  logic signed [OUT_WIDTH-1:0] mac_result,
  input  logic                        mac_valid_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mac_ctrl: TIMEOUT must be at least 1");
  end

  state_t                        state;
  state_t                        state_nxt;
  logic [ADDR_WIDTH:0]           len_q;
  logic [ADDR_WIDTH:0]           issue_cnt;
  logic [ADDR_WIDTH:0]           valid_cnt;
  logic [ADDR_WIDTH:0]           valid_cnt_inc;
  logic                          vin_q;
  logic                          eof_q;
  logic                          err_q;
  logic signed [OUT_WIDTH-1:0]   res_q;
  logic                          active;
  logic                          step;
  logic                          issue;
  logic                          last_issue;
  logic                          vcount;
  logic                          final_hit;
  logic                          accept;
  logic                          reject;
  logic                          timeout;
  logic                          to_clr_q;

  // Shared decode of the current state and stall condition
  always_comb begin
    active        = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN);
    step          = active && !hold;
    issue         = (state == S_RUN) && !hold;
    last_issue    = (state == S_RUN) && (issue_cnt == len_q - CNT_ONE);
    vcount        = step && mac_valid_out && (state != S_CLEAR);
    valid_cnt_inc = valid_cnt + CNT_ONE;
    accept        = (state == S_IDLE) && start && (len != '0);
    reject        = (state == S_IDLE) && start && (len == '0);
    // Capture normally fires on the len-th pulse; the equality fallback
    // covers a count that already completed before DRAIN was reached.
    final_hit     = (state == S_DRAIN) && !hold &&
                    (vcount ? (valid_cnt_inc == len_q) : (valid_cnt == len_q));
  end

`ifdef MAC_CTRL_TIMEOUT_EN
  logic [31:0] wd_cnt;

  assign timeout = (state == S_DRAIN) && !hold && !vcount && !final_hit &&
                   ((wd_cnt + 32'd1) == 32'(TIMEOUT));

  // Drain watchdog: counts unheld DRAIN cycles since the last valid_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt   <= '0;
      to_clr_q <= 1'b0;
    end else begin
      to_clr_q <= timeout;
      if (state != S_DRAIN) begin
        wd_cnt <= '0;
      end else if (!hold) begin
        wd_cnt <= vcount ? '0 : wd_cnt + 32'd1;
      end
    end
  end
`else
  assign timeout  = 1'b0;
  assign to_clr_q = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_CLEAR;
      S_CLEAR: if (!hold) state_nxt = S_RUN;
      S_RUN:   if (issue && last_issue) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (final_hit) begin
          state_nxt = S_DONE;
        end else if (timeout) begin
          state_nxt = S_IDLE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: job length, counters, MAC framing delay, result and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      issue_cnt <= '0;
      valid_cnt <= '0;
      vin_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
      res_q     <= '0;
    end else begin
      err_q <= reject || timeout;
      if (accept) begin
        len_q <= len;
      end
      if (step) begin
        vin_q <= issue;
        eof_q <= issue && last_issue;
        if (state == S_CLEAR) begin
          issue_cnt <= '0;
          valid_cnt <= '0;
        end else begin
          if (issue) begin
            issue_cnt <= issue_cnt + CNT_ONE;
          end
          if (vcount) begin
            valid_cnt <= valid_cnt_inc;
          end
        end
      end
      if (final_hit) begin
        res_q <= mac_result;
      end
    end
  end

  // Output decode
  always_comb begin
    busy         = (state != S_IDLE);
    done         = (state == S_DONE);
    err          = err_q;
    res          = res_q;
    rd_en        = issue;
    rd_addr      = issue_cnt[ADDR_WIDTH-1:0];
    mac_clear    = reset || (state == S_CLEAR) || to_clr_q;
    mac_enable   = step;
    mac_valid_in = vin_q;
    mac_eof      = eof_q;
    mac_a        = rd_a_data;
    mac_b        = rd_b_data;
  end

endmodule

// File: tb/tb_mac_ctrl.sv
// tb_mac_ctrl - self-checking bench for mac_ctrl with behavioural RAMs and a
// two-stage mac model (product register, then accumulate + valid_out).
`timescale 1ns/1ps
module tb_mac_ctrl;
  localparam int AW  = 8;
  localparam int BW  = 8;
  localparam int OW  = 18;
  localparam int ADW = 8;
  localparam int TO  = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic                 hold = 1'b0;
  logic [ADW:0]         len = '0;
  logic                 busy, done, err, rd_en;
  logic signed [OW-1:0] res;
  logic [ADW-1:0]       rd_addr;
  logic signed [AW-1:0] rd_a_data, mac_a;
  logic signed [BW-1:0] rd_b_data, mac_b;
  logic                 mac_clear, mac_enable, mac_valid_in, mac_eof;
  logic signed [OW-1:0] mac_result;
  logic                 mac_valid_out;

  mac_ctrl #(.A_WIDTH(AW), .B_WIDTH(BW), .OUT_WIDTH(OW), .ADDR_WIDTH(ADW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .hold(hold),
    .busy(busy), .done(done), .err(err), .res(res),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
    .mac_clear(mac_clear), .mac_enable(mac_enable), .mac_valid_in(mac_valid_in),
    .mac_eof(mac_eof), .mac_a(mac_a), .mac_b(mac_b),
    .mac_result(mac_result), .mac_valid_out(mac_valid_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // operand RAMs, one-cycle read latency
  logic signed [AW-1:0] mem_a [256];
  logic signed [BW-1:0] mem_b [256];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else if (rd_en) begin
      rd_a_data <= mem_a[rd_addr];
      rd_b_data <= mem_b[rd_addr];
    end
  end

  // mac model
  logic                    pv = 1'b0, vo = 1'b0, vo_kill = 1'b0;
  logic signed [AW+BW-1:0] prod = '0;
  logic signed [OW-1:0]    acc = '0;
  always @(posedge clk) begin
    if (mac_clear) begin
      pv <= 1'b0; vo <= 1'b0; acc <= '0;
    end else if (mac_enable) begin
      pv   <= mac_valid_in;
      prod <= mac_a * mac_b;
      if (pv) acc <= acc + OW'(prod);
      vo   <= pv;
    end
  end
  assign mac_result    = acc;
  assign mac_valid_out = vo & ~vo_kill;

  int n_chk = 0;
  int n_fail = 0;
  int sb[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor state, cleared by the driver before each job
  int vin_n, eof_n, eof_at, done_n, err_n, done_cyc, err_cyc;
  int busy_n, busy_first, rd_n, rd_first, vin_first, addr_bad;

  task automatic clr_mon();
    vin_n = 0; eof_n = 0; eof_at = 0; done_n = 0; err_n = 0; done_cyc = 0; err_cyc = 0;
    busy_n = 0; busy_first = 0; rd_n = 0; rd_first = 0; vin_first = 0; addr_bad = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (busy_n == 0) busy_first = cyc;
        busy_n++;
      end
      if (rd_en) begin
        if (rd_n == 0) rd_first = cyc;
        if (rd_addr != ADW'(rd_n)) addr_bad++;
        rd_n++;
      end
      if (mac_valid_in && mac_enable) begin
        if (vin_n == 0) vin_first = cyc;
        vin_n++;
        if (mac_eof) begin
          eof_n++;
          eof_at = vin_n;
        end
      end
      if (done) begin
        done_n++;
        done_cyc = cyc;
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_res: done with empty queue, res=%0d", res);
        end else begin
          int exp_r;
          exp_r = sb.pop_front();
          if (int'(res) != exp_r) begin
            n_fail++;
            $display("FAIL scoreboard_res: got %0d expected %0d", res, exp_r);
          end
        end
      end
      if (err) begin
        err_n++;
        err_cyc = cyc;
      end
    end
  end

  typedef struct {
    int len;
    int hold_from;
    int hold_to;
    int restart_at;
    int exp_res;
    int exp_err;
    int exp_done_off;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int e;
    int budget;
    @(posedge clk); #1;
    clr_mon();
    start = 1'b1;
    len   = (ADW+1)'(v.len);
    e     = cyc;
    if (v.len != 0) sb.push_back(v.exp_res);
    budget = 0;
    while (done_n == 0 && err_n == 0 && budget < 400) begin
      @(posedge clk); #1;
      budget++;
      start = (v.restart_at >= 0) && (cyc - e == v.restart_at);
      len   = start ? (ADW+1)'(3) : (ADW+1)'(v.len);
      hold  = (cyc - e >= v.hold_from) && (cyc - e <= v.hold_to);
    end
    start = 1'b0;
    hold  = 1'b0;
    chk($sformatf("v%0d_completed", idx), budget < 400, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d_busy_end", idx), busy, 0);
    chk($sformatf("v%0d_done_n", idx), done_n, (v.exp_err != 0) ? 0 : 1);
    chk($sformatf("v%0d_err_n", idx), err_n, v.exp_err);
    if (v.exp_err != 0) begin
      chk($sformatf("v%0d_err_cyc", idx), err_cyc - e, 1);
      chk($sformatf("v%0d_busy_n", idx), busy_n, 0);
      chk($sformatf("v%0d_rd_n", idx), rd_n, 0);
      chk($sformatf("v%0d_vin_n", idx), vin_n, 0);
    end else begin
      chk($sformatf("v%0d_done_cyc", idx), done_cyc - e, v.exp_done_off);
      chk($sformatf("v%0d_vin_n", idx), vin_n, v.len);
      chk($sformatf("v%0d_eof_n", idx), eof_n, 1);
      chk($sformatf("v%0d_eof_at", idx), eof_at, v.len);
      chk($sformatf("v%0d_rd_n", idx), rd_n, v.len);
      chk($sformatf("v%0d_addr_bad", idx), addr_bad, 0);
      chk($sformatf("v%0d_busy_first", idx), busy_first - e, 1);
      chk($sformatf("v%0d_rd_first", idx), rd_first - e, 2);
      chk($sformatf("v%0d_vin_first", idx), vin_first - e, 3);
      chk($sformatf("v%0d_busy_n", idx), busy_n, v.exp_done_off);
      chk($sformatf("v%0d_res_held", idx), res, v.exp_res);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_vin"}, mac_valid_in, 0);
    chk({tag, "_eof"}, mac_eof, 0);
    chk({tag, "_mac_clear"}, mac_clear, 1);
    chk({tag, "_mac_enable"}, mac_enable, 0);
    chk({tag, "_res"}, res, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  vec_t vecs[6];
  vec_t v4;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e;
    // len, hold_from, hold_to, restart_at, exp_res, exp_err, exp_done_off
    vecs[0] = '{15,  -1, -1, -1,  1240, 0,  20};
    vecs[1] = '{15,   5,  8, -1,  1240, 0,  24};
    vecs[2] = '{15,  -1, -1,  6,  1240, 0,  20};
    vecs[3] = '{0,   -1, -1, -1,     0, 1,  -1};
    vecs[4] = '{1,   -1, -1, -1,     1, 0,   6};
    vecs[5] = '{256, -1, -1, -1, 87424, 0, 261};
    v4      = '{4,   -1, -1, -1,    30, 0,   9};
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = AW'(i + 1);
      mem_b[i] = BW'(i + 1);
    end
    clr_mon();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clk);
    chk("por_mac_clear_release", mac_clear, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // reset in the middle of a len=15 job
    @(posedge clk); #1;
    clr_mon();
    start = 1'b1;
    len   = (ADW+1)'(15);
    e     = cyc;
    sb.push_back(1240);
    while (cyc - e < 6) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("midrst_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_done_n", done_n, 0);
    chk("midrst_err_n", err_n, 0);
    run_vec(v4, 6);

`ifdef MAC_CTRL_TIMEOUT_EN
    // drain watchdog with valid_out suppressed
    begin
      int budget;
      vo_kill = 1'b1;
      @(posedge clk); #1;
      clr_mon();
      start = 1'b1;
      len   = (ADW+1)'(2);
      e     = cyc;
      budget = 0;
      while (err_n == 0 && budget < 200) begin
        @(posedge clk); #1;
        start = 1'b0;
        budget++;
      end
      chk("to_completed", budget < 200, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("to_err_cyc", err_cyc - e, 20);
      chk("to_err_n", err_n, 1);
      chk("to_done_n", done_n, 0);
      chk("to_res_unchanged", res, 30);
      chk("to_busy_end", busy, 0);
      vo_kill = 1'b0;
    end
`endif

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
